// File: rtl/a10_datapath.sv
// Single-cycle 32-bit R-type datapath: fetch from an internal ROM, read two
// registers, execute the ALU op and write back, all in one clock.

module a10_regbank #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int AW        = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  // No reset on the storage so preloaded contents survive rst
  logic [DATA_W-1:0] m [0:REG_COUNT-1];

  always_ff @(posedge clk) begin
    if (we) m[waddr] <= wdata;
  end

  assign rdata_a = m[raddr_a];
  assign rdata_b = m[raddr_b];

endmodule

module a10_imem #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] rdata
);

  // Load port is tied off at the top; contents are preloaded externally
  logic [DATA_W-1:0] m [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) m[waddr] <= wdata;
  end

  assign rdata = m[addr];

endmodule

module a10_datapath #(
  parameter int DATA_W     = 32,
  parameter int REG_COUNT  = 32,
  parameter int IMEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] salida
);

  localparam int PC_W = $clog2(IMEM_WORDS);

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic [31:0]       instr;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt_unused;
  logic [5:0]        funct;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] result;
  logic              exec;
  logic              we;

  assign op           = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign shamt_unused = instr[10:6];
  assign funct        = instr[5:0];

  a10_imem #(
    .DATA_W (32),
    .WORDS  (IMEM_WORDS),
    .AW     (PC_W)
  ) imem (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc),
    .rdata (instr)
  );

  a10_regbank #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT),
    .AW        (5)
  ) bank (
    .clk     (clk),
    .we      (we),
    .waddr   (rd),
    .wdata   (result),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (a),
    .rdata_b (b)
  );

  // Unknown op or funct leaves exec low, which turns the word into a NOP
  always_comb begin
    result = '0;
    exec   = 1'b0;
    if (op == 6'd0) begin
      exec = 1'b1;
      case (funct)
        F_ADD:   result = a + b;
        F_SUB:   result = a - b;
        F_AND:   result = a & b;
        F_OR:    result = a | b;
        F_NOR:   result = ~(a | b);
        F_SLT:   result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
        default: exec   = 1'b0;
      endcase
    end
  end

  assign we      = exec && !rst;
  assign pc_next = (pc == PC_W'(IMEM_WORDS - 1)) ? '0 : pc + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      salida <= '0;
    end else begin
      pc <= pc_next;
      if (exec) salida <= result;
    end
  end

endmodule

// File: tb/tb_a10_datapath.sv
// Scoreboard bench for a10_datapath: programs are preloaded hierarchically,
// expected salida values are queued per edge and checked by a monitor.

module tb_a10_datapath;

  logic        clk;
  logic        rst;
  logic [31:0] salida;

  int checks;
  int errors;
  logic [31:0] expq [$];

  localparam logic [31:0] NOPW = 32'h8C00_0000;

  a10_datapath dut (
    .clk    (clk),
    .rst    (rst),
    .salida (salida)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] funct,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge: queue what the next rising edge must produce
  task automatic applyStimulus(input logic [31:0] exp);
    expq.push_back(exp);
    @(negedge clk);
  endtask

  task automatic holdReset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.imem.m[i] = NOPW;
  endtask

  initial begin
    logic [31:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp = expq.pop_front();
        checkOutput("salida", salida, exp);
      end
    end
  end

  initial begin
    clk    = 1'b0;
    rst    = 1'b0;
    checks = 0;
    errors = 0;

    // Reset keeps preloaded bank contents
    #2;
    dut.bank.m[1] = 32'd5;
    dut.bank.m[2] = 32'd3;
    rst = 1'b1;
    #1;
    checkOutput("reset_salida", salida, 32'd0);
    checkOutput("reset_pc", {26'd0, dut.pc}, 32'd0);
    @(negedge clk);
    checkOutput("reset_r1", dut.bank.m[1], 32'd5);
    checkOutput("reset_r2", dut.bank.m[2], 32'd3);

    // add / sub
    holdReset();
    dut.imem.m[0] = rtype(6'h20, 5'd3, 5'd1, 5'd2);
    dut.imem.m[1] = rtype(6'h22, 5'd4, 5'd1, 5'd2);
    rst = 1'b0;
    applyStimulus(32'd8);
    applyStimulus(32'd2);
    applyStimulus(32'd2);
    checkOutput("add_r3", dut.bank.m[3], 32'd8);
    checkOutput("sub_r4", dut.bank.m[4], 32'd2);

    // Logic ops and signed compare
    holdReset();
    dut.bank.m[1] = 32'hF0F0_0000;
    dut.bank.m[2] = 32'h0FF0_FFFF;
    dut.bank.m[5] = 32'h0000_1234;
    dut.imem.m[0] = rtype(6'h24, 5'd7, 5'd1, 5'd2);
    dut.imem.m[1] = rtype(6'h25, 5'd8, 5'd1, 5'd2);
    dut.imem.m[2] = rtype(6'h27, 5'd9, 5'd1, 5'd2);
    dut.imem.m[3] = rtype(6'h2A, 5'd5, 5'd2, 5'd1);
    dut.imem.m[4] = rtype(6'h2A, 5'd10, 5'd1, 5'd2);
    rst = 1'b0;
    applyStimulus(32'h00F0_0000);
    applyStimulus(32'hFFF0_FFFF);
    applyStimulus(32'h000F_0000);
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0000_0001);
    checkOutput("nor_r9", dut.bank.m[9], 32'h000F_0000);
    checkOutput("slt_r5", dut.bank.m[5], 32'd0);

    // Modulo wrap and read-after-write
    holdReset();
    dut.bank.m[1] = 32'hFFFF_FFFF;
    dut.bank.m[2] = 32'd1;
    dut.bank.m[6] = 32'h0000_00AA;
    dut.imem.m[0] = rtype(6'h20, 5'd1, 5'd1, 5'd2);
    dut.imem.m[1] = rtype(6'h20, 5'd6, 5'd1, 5'd1);
    rst = 1'b0;
    applyStimulus(32'd0);
    applyStimulus(32'd0);
    checkOutput("wrap_r1", dut.bank.m[1], 32'd0);
    checkOutput("raw_r6", dut.bank.m[6], 32'd0);

    // NOP words and PC wrap back to word 0
    holdReset();
    dut.bank.m[1] = 32'd5;
    dut.bank.m[2] = 32'd3;
    dut.bank.m[4] = 32'h0000_0077;
    dut.bank.m[7] = 32'h0000_0055;
    dut.imem.m[0]  = rtype(6'h20, 5'd1, 5'd1, 5'd2);
    dut.imem.m[1]  = {6'h23, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
    dut.imem.m[2]  = rtype(6'h3F, 5'd4, 5'd1, 5'd2);
    dut.imem.m[63] = rtype(6'h25, 5'd5, 5'd2, 5'd2);
    rst = 1'b0;
    for (int i = 1; i <= 65; i++)
      applyStimulus((i == 64) ? 32'd3 : (i == 65) ? 32'd11 : 32'd8);
    checkOutput("nop_op_r7", dut.bank.m[7], 32'h0000_0055);
    checkOutput("nop_funct_r4", dut.bank.m[4], 32'h0000_0077);
    checkOutput("rerun_r1", dut.bank.m[1], 32'd11);

    // Reset in the middle of a run
    holdReset();
    dut.bank.m[1] = 32'd5;
    dut.bank.m[2] = 32'd3;
    dut.imem.m[0] = rtype(6'h20, 5'd3, 5'd1, 5'd2);
    dut.imem.m[1] = rtype(6'h20, 5'd1, 5'd1, 5'd2);
    dut.imem.m[2] = rtype(6'h22, 5'd4, 5'd1, 5'd2);
    dut.imem.m[3] = rtype(6'h25, 5'd5, 5'd1, 5'd2);
    dut.imem.m[4] = rtype(6'h20, 5'd6, 5'd1, 5'd1);
    rst = 1'b0;
    applyStimulus(32'd8);
    applyStimulus(32'd8);
    applyStimulus(32'd5);
    applyStimulus(32'd11);
    applyStimulus(32'd16);
    rst = 1'b1;
    #1;
    checkOutput("midrst_salida", salida, 32'd0);
    checkOutput("midrst_pc", {26'd0, dut.pc}, 32'd0);
    @(negedge clk);
    checkOutput("midrst_nowrite_r3", dut.bank.m[3], 32'd8);
    rst = 1'b0;
    applyStimulus(32'd11);
    checkOutput("midrst_r3", dut.bank.m[3], 32'd11);

    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
